// File: rtl/row_transfer_controller_pkg.sv
// Shared constants and state encoding for the row transfer controller
// and the row address generator.
package row_transfer_controller_pkg;

  localparam int ROW_WORDS   = 40;
  localparam int ACTIVE_ROWS = 480;
  localparam int LAST_ROW    = 524;

  localparam int ROW_NUM_W  = 9;
  localparam int CNT_W      = 6;
  localparam int WORD_SHIFT = 4;
  localparam int SLICE_W    = CNT_W + WORD_SHIFT;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    HANDOVER
  } state_t;

  // bit offset of word k inside a row
  function automatic logic [SLICE_W-1:0] word_lsb(
    input logic [CNT_W-1:0] k
  );
    return {k, {WORD_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/row_address_gen.sv
// Word address of word k of a display row: rowNum*40 + k.
// Shift-add form keeps it to two adders, no multiplier.
module row_address_gen
  import row_transfer_controller_pkg::*;
#(
  parameter int ADDR_BITS = 15
) (
  input  logic [ROW_NUM_W-1:0] row_num,
  input  logic [CNT_W-1:0]     k,
  output logic [ADDR_BITS-1:0] addr
);

  logic [ADDR_BITS-1:0] row_ext;

  assign row_ext = ADDR_BITS'(row_num);
  assign addr    = (row_ext << 5) + (row_ext << 3) + ADDR_BITS'(k);

endmodule

// File: rtl/row_transfer_controller.sv
// Per-blanking row mover: writes the displayed row back to frame
// memory, then fetches the next row and hands it to the calculator.
module row_transfer_controller
  import row_transfer_controller_pkg::*;
#(
  parameter int ROW_BITS  = 640,
  parameter int WORD_BITS = 16,
  parameter int ADDR_BITS = 15
) (
  input  logic                 clkDiv,
  input  logic                 rst,
  input  logic                 lineStart,
  input  logic [ROW_NUM_W-1:0] row,
  input  logic [ROW_BITS-1:0]  writeRow,
  output logic [ROW_BITS-1:0]  readRow,
  output logic                 reading,
  output logic [ADDR_BITS-1:0] memAddr,
  output logic [WORD_BITS-1:0] memWriteData,
  input  logic [WORD_BITS-1:0] memReadData,
  output logic                 memRead,
  output logic                 memWrite,
  input  logic                 memAck,
  output logic                 overrun
);

  state_t state, state_nxt;

  logic [CNT_W-1:0]     cnt;
  logic [ROW_NUM_W-1:0] loaded_row;
  logic [ROW_NUM_W-1:0] fetch_row;
  logic [ROW_NUM_W-1:0] xfer_row;
  logic                 loaded_valid;
  logic                 do_fetch;
  logic [ADDR_BITS-1:0] addr;

  logic row_active;
  logic row_last_active;
  logic row_wrap;
  logic start;
  logic in_xfer;
  logic last_word;
  logic word_done;

  assign row_active      = row < ROW_NUM_W'(ACTIVE_ROWS - 1);
  assign row_last_active = row == ROW_NUM_W'(ACTIVE_ROWS - 1);
  assign row_wrap        = row == ROW_NUM_W'(LAST_ROW);

  assign start = lineStart && (state == IDLE) &&
                 (row_active || row_last_active || row_wrap);

  assign in_xfer   = (state == WRITEBACK) || (state == FETCH);
  assign last_word = cnt == CNT_W'(ROW_WORDS - 1);
  assign word_done = in_xfer && memAck;
  assign xfer_row  = (state == WRITEBACK) ? loaded_row : fetch_row;

  row_address_gen #(
    .ADDR_BITS(ADDR_BITS)
  ) u_addr (
    .row_num(xfer_row),
    .k      (cnt),
    .addr   (addr)
  );

  assign memAddr      = in_xfer ? addr : '0;
  assign memWriteData = (state == WRITEBACK) ?
                        writeRow[word_lsb(cnt) +: WORD_BITS] : '0;

  always_ff @(posedge clkDiv or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    reading   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (loaded_valid)          state_nxt = WRITEBACK;
          else if (!row_last_active) state_nxt = FETCH;
        end
      end
      WRITEBACK: begin
        memWrite = 1'b1;
        if (memAck && last_word)
          state_nxt = do_fetch ? FETCH : IDLE;
      end
      FETCH: begin
        memRead = 1'b1;
        if (memAck && last_word) state_nxt = HANDOVER;
      end
      HANDOVER: begin
        reading   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clkDiv or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      loaded_row   <= '0;
      fetch_row    <= '0;
      loaded_valid <= 1'b0;
      do_fetch     <= 1'b0;
      readRow      <= '0;
      overrun      <= 1'b0;
    end else begin
      if (start) begin
        do_fetch  <= !row_last_active;
        fetch_row <= row_wrap ? '0 : row + 1'b1;
      end
      if (lineStart && state != IDLE) overrun <= 1'b1;
      if (word_done) begin
        cnt <= last_word ? '0 : cnt + 1'b1;
        if (state == FETCH)
          readRow[word_lsb(cnt) +: WORD_BITS] <= memReadData;
      end
      // last active row: written back, nothing left loaded
      if (state == WRITEBACK && memAck && last_word && !do_fetch)
        loaded_valid <= 1'b0;
      if (state == HANDOVER) begin
        loaded_row   <= fetch_row;
        loaded_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_row_transfer_controller.sv
// Randomized bench for row_transfer_controller against a row-level
// model of the blanking write-back/fetch sequence.
module tb_row_transfer_controller;

  logic         clkDiv = 1'b0;
  logic         rst;
  logic         lineStart;
  logic [8:0]   row;
  logic [639:0] writeRow;
  logic [639:0] readRow;
  logic         reading;
  logic [14:0]  memAddr;
  logic [15:0]  memWriteData;
  logic [15:0]  memReadData;
  logic         memRead;
  logic         memWrite;
  logic         memAck;
  logic         overrun;

  typedef struct packed {
    logic        wr;
    logic [14:0] addr;
    logic [15:0] data;
  } op_t;

  op_t          ops[$];
  int           rd_cyc[$];
  logic [639:0] rd_row;
  logic [15:0]  mem[0:32767];
  logic [15:0]  ref_mem[0:32767];

  int  ncyc = 0;
  int  ls_n = 0;
  int  pend = 0;
  int  wait_n = 0;
  int  hold_err = 0;
  op_t held;

  int checks = 0;
  int failures = 0;

  logic         m_valid;
  int           m_row;
  logic         m_ovr;
  logic [639:0] m_readrow;

  row_transfer_controller dut (
    .clkDiv      (clkDiv),
    .rst         (rst),
    .lineStart   (lineStart),
    .row         (row),
    .writeRow    (writeRow),
    .readRow     (readRow),
    .reading     (reading),
    .memAddr     (memAddr),
    .memWriteData(memWriteData),
    .memReadData (memReadData),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .memAck      (memAck),
    .overrun     (overrun)
  );

  always #5 clkDiv = ~clkDiv;

  task automatic chk(input string tag, input logic [639:0] got,
                     input logic [639:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // memory with wait_n wait states per word; acks land on the next rising edge
  always @(negedge clkDiv) begin
    op_t cur;
    ncyc++;
    if (memRead || memWrite) begin
      cur = op_t'({memWrite, memAddr, memWrite ? memWriteData : 16'h0});
      if (memRead && memWrite) hold_err++;
      if (pend > 0 && cur != held) hold_err++;
      held = cur;
      if (pend >= wait_n) begin
        memAck = 1'b1;
        memReadData = mem[memAddr];
        ops.push_back(cur);
        if (memWrite) mem[memAddr] = memWriteData;
        pend = 0;
      end else begin
        memAck = 1'b0;
        memReadData = 16'($urandom);
        pend++;
      end
    end else begin
      pend = 0;
      memAck = 1'($urandom_range(0, 1));
      memReadData = 16'($urandom);
    end
    if (reading) begin
      rd_cyc.push_back(ncyc - ls_n);
      rd_row = readRow;
    end
  end

  task automatic reset_checks(input string p);
    chk({p, "_memRead"}, memRead, 0);
    chk({p, "_memWrite"}, memWrite, 0);
    chk({p, "_memAddr"}, memAddr, 0);
    chk({p, "_memWriteData"}, memWriteData, 0);
    chk({p, "_reading"}, reading, 0);
    chk({p, "_readRow"}, readRow, 0);
    chk({p, "_overrun"}, overrun, 0);
  endtask

  // one blanking interval; poke re-pulses lineStart, rst_at aborts
  task automatic do_line(input int r, input int w, input int poke,
                         input int rst_at);
    op_t          exp[$];
    logic [639:0] wr;
    logic [639:0] exp_row;
    bit           wb;
    bit           fe;
    bit           aborted;
    int           frow;
    int           nw;
    int           budget;
    int           a;
    int           napply;

    wb = ((r <= 479) || (r == 524)) && m_valid;
    fe = (r <= 478) || (r == 524);
    frow = (r == 524) ? 0 : r + 1;
    exp_row = '0;
    for (int k = 0; k < 20; k++) wr[k*32 +: 32] = $urandom;
    if (wb)
      for (int k = 0; k < 40; k++)
        exp.push_back(op_t'({1'b1, 15'(m_row*40 + k), wr[k*16 +: 16]}));
    if (fe)
      for (int k = 0; k < 40; k++) begin
        a = frow*40 + k;
        exp.push_back(op_t'({1'b0, 15'(a), 16'h0}));
        exp_row[k*16 +: 16] = (wb && frow == m_row) ?
                              wr[k*16 +: 16] : ref_mem[a];
      end
    nw = exp.size();

    ops.delete();
    rd_cyc.delete();
    hold_err = 0;
    wait_n = w;
    aborted = 0;

    @(negedge clkDiv); #1;
    row = 9'(r);
    writeRow = wr;
    lineStart = 1'b1;
    @(negedge clkDiv); #1;
    lineStart = 1'b0;
    ls_n = ncyc - 1;

    budget = nw*(w + 1) + 6;
    for (int i = 0; i < budget; i++) begin
      @(negedge clkDiv); #1;
      lineStart = (i == poke);
      if (i == poke) row = 9'($urandom_range(0, 524));
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        reset_checks("async_rst");
        @(negedge clkDiv); #1;
        rst = 1'b0;
        aborted = 1;
        break;
      end
    end
    lineStart = 1'b0;

    if (aborted) begin
      napply = ops.size();
      chk("rst_partial_cnt", napply < nw, 1);
      for (int i = 0; i < napply && i < nw; i++) begin
        chk($sformatf("rst_op%0d", i), ops[i], exp[i]);
        if (exp[i].wr) ref_mem[exp[i].addr] = exp[i].data;
      end
      m_valid = 0;
      m_row = 0;
      m_ovr = 0;
      m_readrow = '0;
      return;
    end

    chk($sformatf("op_count_r%0d", r), ops.size(), nw);
    for (int i = 0; i < nw && i < ops.size(); i++) begin
      chk($sformatf("op%0d_r%0d", i, r), ops[i], exp[i]);
      if (ops[i] !== exp[i]) break;
    end
    chk("hold_stable", hold_err, 0);
    chk($sformatf("reading_cnt_r%0d", r), rd_cyc.size(), fe);
    if (fe && rd_cyc.size() > 0) begin
      chk($sformatf("reading_cyc_r%0d", r), rd_cyc[0], nw*(w + 1) + 1);
      chk("row_at_reading", rd_row, exp_row);
    end
    if (fe) m_readrow = exp_row;
    chk("readRow_hold", readRow, m_readrow);
    if (poke >= 0) m_ovr = 1;
    chk("overrun", overrun, m_ovr);

    foreach (exp[i]) if (exp[i].wr) ref_mem[exp[i].addr] = exp[i].data;
    if (r == 479 && wb) m_valid = 0;
    if (fe) begin
      m_valid = 1;
      m_row = frow;
    end
  endtask

  initial begin
    rst = 1'b1;
    lineStart = 1'b0;
    row = '0;
    writeRow = '0;
    memAck = 1'b0;
    memReadData = '0;
    for (int a = 0; a < 32768; a++) begin
      mem[a] = 16'($urandom);
      if (a < 40) mem[a] = 16'hA000 + 16'(a);
      ref_mem[a] = mem[a];
    end
    m_valid = 0;
    m_row = 0;
    m_ovr = 0;
    m_readrow = '0;

    repeat (3) @(negedge clkDiv);
    #1;
    reset_checks("por");
    rst = 1'b0;

    do_line(524, 0, -1, -1);
    chk("row0_word39", readRow[639:624], 16'hA027);
    do_line(0, 0, -1, -1);
    repeat (4)
      do_line($urandom_range(0, 478), $urandom_range(0, 2), -1, -1);
    do_line(478, 0, -1, -1);
    do_line(479, 0, -1, -1);
    do_line(480, 0, -1, -1);
    do_line($urandom_range(481, 523), 1, -1, -1);
    do_line(524, 1, -1, -1);
    do_line(100, 2, -1, -1);
    do_line(200, 0, 60, -1);
    do_line(300, 1, -1, -1);
    do_line(5, 0, -1, 10);
    do_line(0, 0, -1, -1);
    do_line($urandom_range(0, 478), $urandom_range(0, 2), -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
